// File: rtl/intt_output_serializer_if.sv
// intt_output_serializer_if: valid/ready word stream from the serializer to the host/DMA side.
interface intt_output_serializer_if #(
    parameter int DATA_WIDTH  = 60,
    parameter int INDEX_WIDTH = 11
);
    logic [DATA_WIDTH-1:0]  m_data;
    logic [INDEX_WIDTH-1:0] m_index;
    logic                   m_valid;
    logic                   m_ready;
    logic                   m_last;

    modport master(output m_data, m_index, m_valid, m_last, input m_ready);
    modport slave(input m_data, m_index, m_valid, m_last, output m_ready);
endinterface

// File: rtl/intt_output_serializer.sv
// intt_output_serializer: buffers one INTT transform and streams it word-by-word in coefficient order.
// Define INTT_SERIALIZER_DROP_CNT_EN to add a saturating drop_count_o port.
module intt_output_serializer #(
    parameter int LOG_CORE_COUNT = 4,
    parameter int DATA_WIDTH     = 60,
    parameter int ADDR_WIDTH     = 9,
    parameter int BLOCK_COUNT    = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid_i,
    input  logic [DATA_WIDTH-1:0]     data_in_i [2**LOG_CORE_COUNT][2],
    input  logic [ADDR_WIDTH-1:0]     address_in_i,
    output logic                      busy_o,
    output logic                      overflow_o,
`ifdef INTT_SERIALIZER_DROP_CNT_EN
    output logic [15:0]               drop_count_o,
`endif
    intt_output_serializer_if.master  m_if
);
    localparam int LANE_W = LOG_CORE_COUNT + 1;
    localparam int LANES  = 2 ** LANE_W;
    localparam int BLK_W  = $clog2(BLOCK_COUNT);
    localparam int ABW    = (BLK_W > 0) ? BLK_W : 1;
    localparam int IW     = BLK_W + LANE_W;
    localparam int PW     = IW + 1;
    localparam int CW     = BLK_W + 1;
    localparam int WW     = 1 + IW + DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic                  rd_v_q, rd_v_d;
    logic [IW-1:0]         rd_idx_q, rd_idx_d;
    logic                  out_v_q, out_v_d;
    logic                  sk_v_q, sk_v_d;
    logic [WW-1:0]         out_q, out_d;
    logic [WW-1:0]         sk_q, sk_d;
    logic                  ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0] mem [LANES][BLOCK_COUNT];
    logic [DATA_WIDTH-1:0] rdata_q [LANES];
    logic [WW-1:0]         rd_word;
    logic [ABW-1:0]        wr_addr;
    logic [ABW-1:0]        rd_addr;
    logic                  wr_en;
    logic                  drop;
    logic                  issue;
    logic                  pop;
    logic                  load;

    assign drop    = in_valid_i && state_q == DRAIN;
    assign wr_en   = in_valid_i && state_q != DRAIN;
    assign wr_addr = ABW'(address_in_i & ADDR_WIDTH'(BLOCK_COUNT - 1));
    assign rd_addr = ABW'(ptr_q[IW-1:0] >> LANE_W);
    assign pop     = out_v_q && m_if.m_ready;
    assign load    = pop || !out_v_q;
    // Credit check: a read is issued only if output + skid can absorb it whatever m_ready does next.
    assign issue   = state_q == DRAIN && !ptr_q[IW] &&
                     (2'(out_v_q) + 2'(sk_v_q) + 2'(rd_v_q) <= 2'(pop) + 2'd1);
    assign rd_word = {&rd_idx_q, rd_idx_q, rdata_q[rd_idx_q[LANE_W-1:0]]};

    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (wr_en) mem[l][wr_addr] <= data_in_i[l/2][l%2];
            if (issue) rdata_q[l] <= mem[l][rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE && in_valid_i) begin
            state_d = (BLOCK_COUNT == 1) ? DRAIN : FILL;
            cnt_d   = CW'(1);
        end else if (state_q == FILL && in_valid_i) begin
            state_d = (cnt_q == CW'(BLOCK_COUNT - 1)) ? DRAIN : FILL;
            cnt_d   = cnt_q + CW'(1);
        end else if (state_q == DRAIN && pop && out_q[WW-1]) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // out_q is the head of a two-entry queue, sk_q the skid slot behind it.
    always_comb begin
        ptr_d    = (state_q == DRAIN) ? ptr_q + PW'(issue) : '0;
        rd_v_d   = issue;
        rd_idx_d = issue ? ptr_q[IW-1:0] : rd_idx_q;
        out_v_d  = load ? (sk_v_q || rd_v_q) : out_v_q;
        out_d    = !load ? out_q : sk_v_q ? sk_q : rd_v_q ? rd_word : out_q;
        sk_v_d   = load ? (sk_v_q && rd_v_q) : (sk_v_q || rd_v_q);
        sk_d     = (rd_v_q && (sk_v_q || !load)) ? rd_word : sk_q;
        ovf_d    = ovf_q || drop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            rd_v_q   <= 1'b0;
            rd_idx_q <= '0;
            out_v_q  <= 1'b0;
            out_q    <= '0;
            sk_v_q   <= 1'b0;
            sk_q     <= '0;
            ovf_q    <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            rd_v_q   <= rd_v_d;
            rd_idx_q <= rd_idx_d;
            out_v_q  <= out_v_d;
            out_q    <= out_d;
            sk_v_q   <= sk_v_d;
            sk_q     <= sk_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef INTT_SERIALIZER_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    assign drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_cnt_q <= '0;
        else drop_cnt_q <= drop_cnt_d;
    end

    assign drop_count_o = drop_cnt_q;
`endif

    assign busy_o       = state_q != IDLE;
    assign overflow_o   = ovf_q;
    assign m_if.m_valid = out_v_q;
    assign m_if.m_data  = out_q[DATA_WIDTH-1:0];
    assign m_if.m_index = out_q[DATA_WIDTH+IW-1:DATA_WIDTH];
    assign m_if.m_last  = out_q[WW-1];
endmodule

// File: tb/tb_intt_output_serializer.sv
// tb_intt_output_serializer: directed checks of fill order, latency, backpressure, overflow and reset.
module tb_intt_output_serializer;
    localparam int DW      = 60;
    localparam int AW      = 9;
    localparam int BC      = 4;
    localparam int IW      = 5;
    localparam int TOTAL   = 16;
    localparam int B_IW    = 11;
    localparam int B_TOTAL = 2048;

    typedef struct { logic [AW-1:0] addr; int blk; logic busy; } fill_vec_t;
    typedef struct { logic [IW-1:0] idx; logic [DW-1:0] data; logic last; } out_vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          in_valid = 1'b0;
    logic [AW-1:0] address_in = '0;
    logic [DW-1:0] data_in [2][2];
    logic          busy, overflow;
    logic          in_valid_b = 1'b0;
    logic [AW-1:0] address_in_b = '0;
    logic [DW-1:0] data_b [16][2];
    logic          busy_b, overflow_b;
`ifdef INTT_SERIALIZER_DROP_CNT_EN
    logic [15:0]   drop_count, drop_count_b;
`endif

    intt_output_serializer_if #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW)) sif ();
    intt_output_serializer_if #(.DATA_WIDTH(DW), .INDEX_WIDTH(B_IW)) bif ();

    intt_output_serializer #(.LOG_CORE_COUNT(1), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_COUNT(BC)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .data_in_i(data_in),
        .address_in_i(address_in), .busy_o(busy), .overflow_o(overflow),
`ifdef INTT_SERIALIZER_DROP_CNT_EN
        .drop_count_o(drop_count),
`endif
        .m_if(sif)
    );

    intt_output_serializer dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_b), .data_in_i(data_b),
        .address_in_i(address_in_b), .busy_o(busy_b), .overflow_o(overflow_b),
`ifdef INTT_SERIALIZER_DROP_CNT_EN
        .drop_count_o(drop_count_b),
`endif
        .m_if(bif)
    );

    int        checks = 0;
    int        errors = 0;
    int        got;
    fill_vec_t fill_tbl [4];
    out_vec_t  out_tbl [TOTAL];
    logic [5:0] ready_pat = 6'b101001;

    function automatic logic [DW-1:0] enc(input int a, input int k, input int h, input int seed);
        return (DW'(seed) << 24) | (DW'(a) << 8) | (DW'(k) << 4) | DW'(h);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_expected(input int seed);
        for (int a = 0; a < BC; a++)
            for (int k = 0; k < 2; k++)
                for (int h = 0; h < 2; h++)
                    out_tbl[a*4+k*2+h] = '{idx: IW'(a*4+k*2+h), data: enc(a, k, h, seed),
                                          last: (a*4+k*2+h == TOTAL-1)};
    endtask

    task automatic fill(input int seed, input int gap);
        for (int v = 0; v < 4; v++) begin
            in_valid = 1'b1;
            address_in = fill_tbl[v].addr;
            for (int k = 0; k < 2; k++)
                for (int h = 0; h < 2; h++)
                    data_in[k][h] = enc(fill_tbl[v].blk, k, h, seed);
            @(negedge clk);
            in_valid = 1'b0;
            check("fill_busy", busy, fill_tbl[v].busy);
            if (v != 3) repeat (gap) @(negedge clk);
        end
        check("lat_edge1_valid", sif.m_valid, 1'b0);
        @(negedge clk);
        check("lat_edge2_valid", sif.m_valid, 1'b0);
        @(negedge clk);
        check("lat_edge3_valid", sif.m_valid, 1'b1);
    endtask

    task automatic drain(input int mode, input int pulses, input int stop_after);
        int cyc = 0;
        logic stalled = 1'b0;
        logic [DW-1:0] pd = '0;
        logic [IW-1:0] pi = '0;
        logic done = 1'b0;
        got = 0;
        while (!done && cyc < 400) begin
            sif.m_ready = (mode == 1) ? ready_pat[cyc % 6] : 1'b1;
            in_valid = (cyc < 3 * pulses) && (cyc % 3 == 1);
            address_in = '0;
            for (int k = 0; k < 2; k++)
                for (int h = 0; h < 2; h++)
                    data_in[k][h] = '1;
            if (stalled) begin
                check("stall_data", sif.m_data, pd);
                check("stall_index", sif.m_index, pi);
            end
            if (sif.m_valid && sif.m_ready) begin
                if (got < TOTAL) begin
                    check("out_index", sif.m_index, out_tbl[got].idx);
                    check("out_data", sif.m_data, out_tbl[got].data);
                    check("out_last", sif.m_last, out_tbl[got].last);
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL extra_word: got index %0d expected no transfer", sif.m_index);
                end
                got++;
                done = sif.m_last || got == stop_after || got > TOTAL;
            end
            stalled = sif.m_valid && !sif.m_ready;
            pd = sif.m_data;
            pi = sif.m_index;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        sif.m_ready = 1'b1;
        check("drain_done", done, 1'b1);
    endtask

    initial begin
        int bn;
        fill_tbl = '{'{9'h003, 3, 1'b1}, '{9'h105, 1, 1'b1}, '{9'h000, 0, 1'b1}, '{9'h00A, 2, 1'b1}};
        sif.m_ready = 1'b1;
        bif.m_ready = 1'b1;
        for (int k = 0; k < 2; k++) for (int h = 0; h < 2; h++) data_in[k][h] = '0;
        for (int k = 0; k < 16; k++) for (int h = 0; h < 2; h++) data_b[k][h] = '0;
        repeat (2) @(negedge clk);
        check("rst_valid", sif.m_valid, 1'b0);
        check("rst_last", sif.m_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_data", sif.m_data, '0);
        check("rst_index", sif.m_index, '0);
        check("rst_busy_b", busy_b, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        set_expected(1);
        fill(1, 0);
        drain(0, 0, 0);
        check("t1_count", got, TOTAL);
        check("t1_idle_valid", sif.m_valid, 1'b0);
        check("t1_idle_busy", busy, 1'b0);
        check("t1_overflow", overflow, 1'b0);

        set_expected(2);
        fill(2, 2);
        drain(1, 0, 0);
        check("t2_count", got, TOTAL);
        check("t2_idle_busy", busy, 1'b0);

        set_expected(3);
        fill(3, 0);
        drain(0, 3, 0);
        check("t3_count", got, TOTAL);
        check("t3_overflow", overflow, 1'b1);
`ifdef INTT_SERIALIZER_DROP_CNT_EN
        check("t3_drop_count", drop_count, 16'd3);
`endif
        repeat (3) @(negedge clk);
        check("t3_overflow_sticky", overflow, 1'b1);
        check("t3_idle_busy", busy, 1'b0);

        set_expected(4);
        fill(4, 0);
        drain(0, 0, 5);
        check("t4_partial", got, 5);
        rst_n = 1'b0;
        #1;
        check("t4_rst_valid", sif.m_valid, 1'b0);
        check("t4_rst_busy", busy, 1'b0);
        check("t4_rst_overflow", overflow, 1'b0);
        check("t4_rst_index", sif.m_index, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_expected(5);
        fill(5, 0);
        drain(1, 0, 0);
        check("t4_restart_count", got, TOTAL);

        for (int a = 0; a < 64; a++) begin
            in_valid_b = 1'b1;
            address_in_b = AW'(63 - a);
            for (int k = 0; k < 16; k++)
                for (int h = 0; h < 2; h++)
                    data_b[k][h] = enc(63 - a, k, h, 7);
            @(negedge clk);
        end
        in_valid_b = 1'b0;
        bn = 0;
        for (int c = 0; c < 2200 && bn < B_TOTAL; c++) begin
            if (bif.m_valid) begin
                check("big_index", bif.m_index, bn);
                check("big_data", bif.m_data, enc(bn >> 5, (bn >> 1) & 15, bn & 1, 7));
                check("big_last", bif.m_last, bn == B_TOTAL - 1);
                bn++;
            end
            @(negedge clk);
        end
        check("big_count", bn, B_TOTAL);
        check("big_idle_valid", bif.m_valid, 1'b0);
        check("big_idle_busy", busy_b, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/intt_output_serializer.md
Name: intt_output_serializer

Overview:
- Sits directly downstream of the INTT processor.
- Captures the parallel result blocks the processor emits: per valid cycle, 2^LOG_CORE_COUNT cores x 2 words of 60 bits, tagged with a 9-bit address.
- Buffers one complete transform.
- Streams it out one word per transfer over a valid/ready interface in natural coefficient order, toward the host/DMA side.

Parameters:
- LOG_CORE_COUNT, 4, log2 of core count; must match the processor.
- DATA_WIDTH, 60, width of one result word.
- ADDR_WIDTH, 9, width of the block address from the processor.
- BLOCK_COUNT, 64, blocks per transform; must be a power of two and <= 2^ADDR_WIDTH.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  data_in/address_in hold a valid block this cycle.
- data_in  in  DATA_WIDTH x [2^LOG_CORE_COUNT][2]  result block (unpacked array, same shape as the processor output).
- address_in  in  ADDR_WIDTH  block address; only the low log2(BLOCK_COUNT) bits are used.
- busy  out  1  high while in FILL or DRAIN.
- m_data  out  DATA_WIDTH  output word.
- m_index  out  log2(BLOCK_COUNT)+LOG_CORE_COUNT+1  linear index of m_data.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts.
- m_last  out  1  final word of the transform.
- overflow  out  1  sticky; a block arrived while in DRAIN.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State IDLE; block counter and read pointer 0.
  - m_valid=0, m_last=0, busy=0, overflow=0, m_data=0, m_index=0.
  - Buffer contents undefined.
- Storage:
  - Per lane (core k, half h), one memory of depth BLOCK_COUNT x DATA_WIDTH, 1-cycle synchronous read latency (BRAM-inferable).
  - All 2^(LOG_CORE_COUNT+1) lanes written in parallel at address_in.
- States: IDLE, FILL, DRAIN.
- IDLE:
  - in_valid=1 writes the block, sets block count to 1, moves to FILL.
  - If BLOCK_COUNT==1, goes straight to DRAIN.
- FILL:
  - Each in_valid cycle writes all lanes and increments the count.
  - When the write making count==BLOCK_COUNT occurs, next state is DRAIN.
  - Duplicate addresses overwrite and still count; no detection.
- DRAIN:
  - Output order for a from 0..BLOCK_COUNT-1, k from 0..2^LOG_CORE_COUNT-1, h from 0..1: m_data = mem[k][h][a], m_index = (a << (LOG_CORE_COUNT+1)) | (k<<1) | h.
  - First m_valid rises exactly 2 cycles after the DRAIN entry edge (one-cycle read latency plus output register).
  - Standard valid/ready semantics:
    - m_data, m_index and m_last held stable while m_valid=1 and m_ready=0.
    - Transfer on m_valid & m_ready.
    - No combinational path from m_ready to m_valid.
  - Throughput 1 word/cycle with m_ready held high. A prefetch/skid register of depth 2 is required so a ready drop never loses or duplicates a word.
  - m_last=1 only with index 2^(LOG_CORE_COUNT+1)*BLOCK_COUNT-1.
  - The cycle after the last transfer: m_valid=0, state IDLE, busy=0.
  - in_valid during the final-transfer cycle is treated as DRAIN and flagged, not stored.
- Overflow:
  - in_valid=1 while in DRAIN: data discarded, overflow set.
  - overflow cleared only by reset.
- busy=1 in FILL and DRAIN, 0 in IDLE.
- Reset mid-FILL or mid-DRAIN aborts immediately to reset values; the next transform starts cleanly from IDLE.

Optional Feature:
- Macro INTT_SERIALIZER_DROP_CNT_EN.
- Defined:
  - Adds output port drop_count, 16 bits, reset 0.
  - Increments on each discarded in_valid cycle in DRAIN; saturates at 16'hFFFF.
- Undefined:
  - Port and counter absent.
  - overflow behaviour unchanged.

Test Plan:
- Fill/drain order (LOG_CORE_COUNT=1, BLOCK_COUNT=4):
  - Stimulus: 4 blocks at addresses 3,1,0,2 with word value = {addr,k,h} encoded; m_ready=1.
  - Required: 16 transfers, m_index 0..15, m_data matching mem[k][h][a], m_last only on index 15, busy low the cycle after.
- Latency:
  - Stimulus: last block written at cycle T.
  - Required: m_valid first high at T+3 (DRAIN entry edge T+1, +2 cycles).
- Backpressure:
  - Stimulus: m_ready toggled 1,0,0,1,0,1... for the whole drain.
  - Required: no lost or duplicate words, indices strictly ascending, m_data stable while stalled.
- Overflow:
  - Stimulus: in_valid pulsed during DRAIN.
  - Required: overflow=1 and stays 1, output stream unchanged; with INTT_SERIALIZER_DROP_CNT_EN, drop_count equals the number of pulses (e.g. 3).
- Reset mid-DRAIN:
  - Stimulus: rst_n=0 after 5 transfers, then a fresh transform.
  - Required: m_valid=0 immediately; the new drain starts at m_index 0.
- Default parameters:
  - Stimulus: 64 blocks.
  - Required: 2048 transfers, m_last on index 2047.
